// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the generic pipeline-stage register: default widths
// for the EX/MEM instance and the skid-buffer state encoding.
package pipe_stage_skid_pkg;

  localparam int unsigned EXMEM_CTRL_W = 7;
  localparam int unsigned EXMEM_DATA_W = 201;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  function automatic logic [1:0] beat_count(input logic main_valid, input logic skid_valid);
    return {1'b0, main_valid} + {1'b0, skid_valid};
  endfunction

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One beat of storage (control + payload + valid). Clear zeroes everything,
// load captures a beat, drop invalidates and zeroes control but keeps payload.
module pipe_stage_skid_slot #(
  parameter int unsigned CTRL_W = 7,
  parameter int unsigned DATA_W = 201
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    // NOTE: every next-state variable gets a default first, so no path infers a latch.
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline-stage register with valid/ready handshake, flush and
// an optional 2-entry skid buffer that keeps in_ready off the combinational path.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned CTRL_W = EXMEM_CTRL_W,
  parameter int unsigned DATA_W = EXMEM_DATA_W,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              accept, emit;
  logic              main_load, main_drop;
  logic [CTRL_W-1:0] main_ctrl_in;
  logic [DATA_W-1:0] main_data_in;
  logic              skid_valid;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  pipe_stage_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .drop_i  (main_drop),
    .clear_i (flush),
    .ctrl_i  (main_ctrl_in),
    .data_i  (main_data_in),
    .valid_o (out_valid),
    .ctrl_o  (out_ctrl),
    .data_o  (out_data)
  );

  assign occupancy = beat_count(out_valid, skid_valid);

  if (SKID != 0) begin : g_skid
    skid_state_e       state_q, state_d;
    logic              skid_load, skid_drop;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    pipe_stage_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load_i  (skid_load),
      .drop_i  (skid_drop),
      .clear_i (flush),
      .ctrl_i  (in_ctrl),
      .data_i  (in_data),
      .valid_o (skid_valid),
      .ctrl_o  (skid_ctrl),
      .data_o  (skid_data)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_EMPTY;
      else     state_q <= state_d;
    end

    always_comb begin
      state_d = state_q;
      if (flush) begin
        state_d = ST_EMPTY;
      end else begin
        case (state_q)
          ST_EMPTY: if (accept) state_d = ST_ONE;
          ST_ONE: begin
            if (accept && !emit)      state_d = ST_TWO;
            else if (emit && !accept) state_d = ST_EMPTY;
          end
          ST_TWO:   if (emit) state_d = ST_ONE;
          default:  state_d = ST_EMPTY;
        endcase
      end
    end

    // The skid slot only ever holds the younger beat; it refills main on emit.
    always_comb begin
      main_load    = 1'b0;
      main_drop    = 1'b0;
      skid_load    = 1'b0;
      skid_drop    = 1'b0;
      main_ctrl_in = in_ctrl;
      main_data_in = in_data;
      case (state_q)
        ST_EMPTY: main_load = accept;
        ST_ONE: begin
          main_load = accept & emit;
          skid_load = accept & ~emit;
          main_drop = emit & ~accept;
        end
        ST_TWO: begin
          main_load    = emit;
          skid_drop    = emit;
          main_ctrl_in = skid_ctrl;
          main_data_in = skid_data;
        end
        default: ;
      endcase
    end

    assign in_ready = (state_q != ST_TWO);
  end else begin : g_flat
    assign skid_valid   = 1'b0;
    assign in_ready     = out_ready | ~out_valid;
    assign main_load    = accept;
    assign main_drop    = emit & ~accept;
    assign main_ctrl_in = in_ctrl;
    assign main_data_in = in_data;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: drives one stimulus stream into a SKID=1 and a
// SKID=0 instance and checks each against directed expectations and a queue model.
module tb_pipe_stage_skid;

  localparam int unsigned CTRL_W = 7;
  localparam int unsigned DATA_W = 201;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush, in_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;

  logic              s_in_ready, s_out_valid, f_in_ready, f_out_valid;
  logic [CTRL_W-1:0] s_out_ctrl, f_out_ctrl;
  logic [DATA_W-1:0] s_out_data, f_out_data;
  logic [1:0]        s_occ, f_occ;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .occupancy(s_occ)
  );

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0)) u_flat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(f_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(f_out_valid), .out_ready(out_ready), .out_ctrl(f_out_ctrl), .out_data(f_out_data),
    .occupancy(f_occ)
  );

  // Status bundle: {out_valid, out_ctrl, occupancy, in_ready}
  wire [10:0] s_stat = {s_out_valid, s_out_ctrl, s_occ, s_in_ready};
  wire [10:0] f_stat = {f_out_valid, f_out_ctrl, f_occ, f_in_ready};

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [223:0] t;
    for (int k = 0; k < 7; k++) t[k*32 +: 32] = $urandom();
    return t[DATA_W-1:0];
  endfunction

  task automatic test_reset();
    logic [10:0] e;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #3;
    e = {1'b0, 7'h00, 2'd0, 1'b1};
    checks++; if (s_stat !== e) begin failures++; $display("FAIL reset_skid_stat: got %h expected %h", s_stat, e); end
    checks++; if (s_out_data !== '0) begin failures++; $display("FAIL reset_skid_data: got %h expected 0", s_out_data); end
    checks++; if (f_stat !== e) begin failures++; $display("FAIL reset_flat_stat: got %h expected %h", f_stat, e); end
    checks++; if (f_out_data !== '0) begin failures++; $display("FAIL reset_flat_data: got %h expected 0", f_out_data); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (s_stat !== e) begin failures++; $display("FAIL post_reset_skid_stat: got %h expected %h", s_stat, e); end
    checks++; if (f_stat !== e) begin failures++; $display("FAIL post_reset_flat_stat: got %h expected %h", f_stat, e); end
  endtask

  task automatic test_streaming();
    logic [10:0]       e;
    logic [DATA_W-1:0] ed;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 7'h41, DATA_W'(i), 1'b1, 1'b0);
      checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, s_in_ready); end
      tick();
      e  = {1'b1, 7'h41, 2'd1, 1'b1};
      ed = DATA_W'(i);
      checks++; if (s_stat !== e) begin failures++; $display("FAIL stream_skid_stat[%0d]: got %h expected %h", i, s_stat, e); end
      checks++; if (s_out_data !== ed) begin failures++; $display("FAIL stream_skid_data[%0d]: got %h expected %h", i, s_out_data, ed); end
      checks++; if (f_stat !== e) begin failures++; $display("FAIL stream_flat_stat[%0d]: got %h expected %h", i, f_stat, e); end
      checks++; if (f_out_data !== ed) begin failures++; $display("FAIL stream_flat_data[%0d]: got %h expected %h", i, f_out_data, ed); end
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    e  = {1'b0, 7'h00, 2'd0, 1'b1};
    ed = DATA_W'(9);
    checks++; if (s_stat !== e) begin failures++; $display("FAIL stream_drain_stat: got %h expected %h", s_stat, e); end
    checks++; if (s_out_data !== ed) begin failures++; $display("FAIL stream_drain_data_hold: got %h expected %h", s_out_data, ed); end
  endtask

  task automatic test_stall();
    logic [10:0]       e;
    logic [DATA_W-1:0] da, db, dc;
    da = rand_data(); db = rand_data(); dc = rand_data();
    drive(1'b1, 7'h12, da, 1'b0, 1'b0);
    tick();
    e = {1'b1, 7'h12, 2'd1, 1'b1};
    checks++; if (s_stat !== e) begin failures++; $display("FAIL stall_a_stat: got %h expected %h", s_stat, e); end
    drive(1'b1, 7'h34, db, 1'b0, 1'b0);
    tick();
    e = {1'b1, 7'h12, 2'd2, 1'b0};
    checks++; if (s_stat !== e) begin failures++; $display("FAIL stall_full_stat: got %h expected %h", s_stat, e); end
    checks++; if (s_out_data !== da) begin failures++; $display("FAIL stall_full_data: got %h expected %h", s_out_data, da); end
    drive(1'b1, 7'h56, dc, 1'b0, 1'b0);
    tick();
    checks++; if (s_stat !== e) begin failures++; $display("FAIL stall_reject_stat: got %h expected %h", s_stat, e); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    e = {1'b1, 7'h34, 2'd1, 1'b1};
    checks++; if (s_stat !== e) begin failures++; $display("FAIL stall_release_b_stat: got %h expected %h", s_stat, e); end
    checks++; if (s_out_data !== db) begin failures++; $display("FAIL stall_release_b_data: got %h expected %h", s_out_data, db); end
    tick();
    e = {1'b0, 7'h00, 2'd0, 1'b1};
    checks++; if (s_stat !== e) begin failures++; $display("FAIL stall_empty_stat: got %h expected %h", s_stat, e); end
    checks++; if (s_out_data !== db) begin failures++; $display("FAIL stall_empty_data_hold: got %h expected %h", s_out_data, db); end
  endtask

  task automatic test_flush();
    logic [10:0] e;
    drive(1'b1, 7'h11, rand_data(), 1'b0, 1'b0);
    tick();
    drive(1'b1, 7'h22, rand_data(), 1'b0, 1'b0);
    tick();
    checks++; if (s_occ !== 2'd2) begin failures++; $display("FAIL flush_setup_occ: got %0d expected 2", s_occ); end
    drive(1'b1, 7'h77, rand_data(), 1'b0, 1'b1);
    tick();
    e = {1'b0, 7'h00, 2'd0, 1'b1};
    checks++; if (s_stat !== e) begin failures++; $display("FAIL flush_two_stat: got %h expected %h", s_stat, e); end
    checks++; if (s_out_data !== '0) begin failures++; $display("FAIL flush_two_data: got %h expected 0", s_out_data); end
    checks++; if (f_stat !== e) begin failures++; $display("FAIL flush_flat_stat: got %h expected %h", f_stat, e); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL flush_ghost[%0d]: got %b expected 0", i, s_out_valid); end
    end
    drive(1'b1, 7'h21, rand_data(), 1'b1, 1'b0);
    tick();
    drive(1'b1, 7'h22, rand_data(), 1'b1, 1'b1);
    tick();
    checks++; if (s_stat !== e) begin failures++; $display("FAIL flush_one_stat: got %h expected %h", s_stat, e); end
    checks++; if (f_stat !== e) begin failures++; $display("FAIL flush_one_flat_stat: got %h expected %h", f_stat, e); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    checks++; if (s_stat !== e) begin failures++; $display("FAIL flush_discard_stat: got %h expected %h", s_stat, e); end
  endtask

  task automatic test_bubble();
    logic [10:0]       e;
    logic [DATA_W-1:0] dx;
    dx = rand_data();
    drive(1'b1, 7'h7F, dx, 1'b1, 1'b0);
    tick();
    e = {1'b1, 7'h7F, 2'd1, 1'b1};
    checks++; if (f_stat !== e) begin failures++; $display("FAIL bubble_beat_stat: got %h expected %h", f_stat, e); end
    checks++; if (f_out_data !== dx) begin failures++; $display("FAIL bubble_beat_data: got %h expected %h", f_out_data, dx); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    e = {1'b0, 7'h00, 2'd0, 1'b1};
    checks++; if (f_stat !== e) begin failures++; $display("FAIL bubble_stat: got %h expected %h", f_stat, e); end
    checks++; if (f_out_data !== dx) begin failures++; $display("FAIL bubble_data_hold: got %h expected %h", f_out_data, dx); end
  endtask

  task automatic test_async_reset();
    logic [10:0]       e;
    logic [DATA_W-1:0] de;
    drive(1'b1, 7'h31, rand_data(), 1'b0, 1'b0);
    tick();
    drive(1'b1, 7'h32, rand_data(), 1'b0, 1'b0);
    tick();
    checks++; if (s_occ !== 2'd2) begin failures++; $display("FAIL areset_setup_occ: got %0d expected 2", s_occ); end
    #2 rst = 1'b1;
    #1;
    e = {1'b0, 7'h00, 2'd0, 1'b1};
    checks++; if (s_stat !== e) begin failures++; $display("FAIL areset_skid_stat: got %h expected %h", s_stat, e); end
    checks++; if (s_out_data !== '0) begin failures++; $display("FAIL areset_skid_data: got %h expected 0", s_out_data); end
    checks++; if (f_stat !== e) begin failures++; $display("FAIL areset_flat_stat: got %h expected %h", f_stat, e); end
    checks++; if (f_out_data !== '0) begin failures++; $display("FAIL areset_flat_data: got %h expected 0", f_out_data); end
    @(negedge clk);
    rst = 1'b0;
    de = rand_data();
    drive(1'b1, 7'h0F, de, 1'b1, 1'b0);
    tick();
    e = {1'b1, 7'h0F, 2'd1, 1'b1};
    checks++; if (s_stat !== e) begin failures++; $display("FAIL areset_restart_stat: got %h expected %h", s_stat, e); end
    checks++; if (s_out_data !== de) begin failures++; $display("FAIL areset_restart_data: got %h expected %h", s_out_data, de); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_random();
    beat_t             sq[$];
    beat_t             fq[$];
    logic [DATA_W-1:0] hold_s, hold_f;
    logic              v, ordy, fl, s_rdy, f_rdy, s_em, f_em;
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic [10:0]       e;
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    tick();
    hold_s = '0;
    hold_f = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      v    = ($urandom_range(3) != 0);
      ordy = ($urandom_range(2) != 0);
      fl   = ($urandom_range(63) == 0);
      c    = CTRL_W'($urandom());
      d    = rand_data();
      drive(v, c, d, ordy, fl);
      #1;
      s_rdy = (sq.size() < 2);
      f_rdy = ordy || (fq.size() == 0);
      e = {sq.size() != 0, (sq.size() != 0) ? sq[0].ctrl : 7'h00, 2'(sq.size()), s_rdy};
      checks++; if (s_stat !== e) begin failures++; $display("FAIL rand_skid_stat[%0d]: got %h expected %h", cyc, s_stat, e); end
      checks++; if (s_out_data !== hold_s) begin failures++; $display("FAIL rand_skid_data[%0d]: got %h expected %h", cyc, s_out_data, hold_s); end
      e = {fq.size() != 0, (fq.size() != 0) ? fq[0].ctrl : 7'h00, 2'(fq.size()), f_rdy};
      checks++; if (f_stat !== e) begin failures++; $display("FAIL rand_flat_stat[%0d]: got %h expected %h", cyc, f_stat, e); end
      checks++; if (f_out_data !== hold_f) begin failures++; $display("FAIL rand_flat_data[%0d]: got %h expected %h", cyc, f_out_data, hold_f); end
      s_em = (sq.size() != 0) && ordy;
      f_em = (fq.size() != 0) && ordy;
      if (s_em) void'(sq.pop_front());
      if (f_em) void'(fq.pop_front());
      if (fl) begin
        sq.delete();
        fq.delete();
        hold_s = '0;
        hold_f = '0;
      end else begin
        if (v && s_rdy) sq.push_back('{ctrl: c, data: d});
        if (v && f_rdy) fq.push_back('{ctrl: c, data: d});
      end
      if (sq.size() != 0) hold_s = sq[0].data;
      if (fq.size() != 0) hold_f = fq[0].data;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_bubble();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
